// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32 I/S-type instruction encoder.
// The encoder sits on the slave side and the producer/consumer on the master side.
interface instr_encoder_if #(
    parameter int DPW  = 32,
    parameter int CNTW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [DPW-1:0]  imm_i;
    logic            immsrc_i;
    logic [6:0]      opcode_i;
    logic [2:0]      funct3_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rdrs2_i;
    logic            out_valid;
    logic            out_ready;
    logic [DPW-1:0]  out_instr;
    logic            out_err;
    logic [CNTW-1:0] enc_count;
    logic [7:0]      err_count;

    modport master (
        output in_valid, imm_i, immsrc_i, opcode_i, funct3_i, rs1_i, rdrs2_i, out_ready,
        input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );

    modport slave (
        input  in_valid, imm_i, immsrc_i, opcode_i, funct3_i, rs1_i, rdrs2_i, out_ready,
        output in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs I/S-type instruction fields into a 32-bit word behind a main register plus
// one skid register, so upstream sees a registered ready and order is preserved.
module instr_encoder #(
    parameter int DPW  = 32,
    parameter int CNTW = 16
) (
    input  logic           clk,
    input  logic           rst,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e            state_q, state_d;
    logic [DPW-1:0]  main_instr_q, main_instr_d;
    logic [DPW-1:0]  skid_instr_q, skid_instr_d;
    logic            main_err_q, main_err_d;
    logic            skid_err_q, skid_err_d;
    logic            in_ready_q, in_ready_d;
    logic [CNTW-1:0] enc_count_q, enc_count_d;
    logic [7:0]      err_count_q, err_count_d;

    logic [DPW-1:0]  enc_instr;
    logic            enc_err;
    logic            accept;
    logic            consume;

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = (state_q != EMPTY) & bus.out_ready;

    // Immediate fits in 12 signed bits only if every bit from 11 upward matches the sign.
    always_comb begin
        enc_instr = '0;
        if (bus.immsrc_i) begin
            enc_instr[31:0] = {bus.imm_i[11:5], bus.rdrs2_i, bus.rs1_i, bus.funct3_i,
                               bus.imm_i[4:0], bus.opcode_i};
        end else begin
            enc_instr[31:0] = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i,
                               bus.rdrs2_i, bus.opcode_i};
        end
        enc_err = ~((&bus.imm_i[DPW-1:11]) | ~(|bus.imm_i[DPW-1:11]));
    end

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_err_d   = main_err_q;
        skid_instr_d = skid_instr_q;
        skid_err_d   = skid_err_q;
        enc_count_d  = enc_count_q;
        err_count_d  = err_count_q;

        if (accept) begin
            enc_count_d = enc_count_q + CNTW'(1);
            if (enc_err && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    main_instr_d = enc_instr;
                    main_err_d   = enc_err;
                end
            end
            ONE: begin
                case ({accept, consume})
                    2'b10: begin
                        state_d      = FULL;
                        skid_instr_d = enc_instr;
                        skid_err_d   = enc_err;
                    end
                    2'b01: begin
                        state_d = EMPTY;
                    end
                    2'b11: begin
                        main_instr_d = enc_instr;
                        main_err_d   = enc_err;
                    end
                    default: begin
                        state_d = ONE;
                    end
                endcase
            end
            FULL: begin
                // in_ready is low here, so only the skid-to-main move can happen.
                if (consume) begin
                    state_d      = ONE;
                    main_instr_d = skid_instr_q;
                    main_err_d   = skid_err_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_instr_q <= '0;
            main_err_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            enc_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_err_q   <= main_err_d;
            skid_instr_q <= skid_instr_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
            enc_count_q  <= enc_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_instr = main_instr_q;
    assign bus.out_err   = main_err_q & (state_q != EMPTY);
    assign bus.enc_count = enc_count_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vectors, handshake corner sequences and a random
// run checked against a queue-based model of the two-entry buffer.
module tb_instr_encoder;
    localparam int CNTW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.DPW(32), .CNTW(CNTW)) bus ();

    instr_encoder #(.DPW(32), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] imm;
        logic        immsrc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rdrs2;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } ent_t;

    vec_t vecs[8];
    ent_t mq[$];
    int   m_enc;
    int   m_err;
    int   n_cmp;
    int   n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model encoding built from field weights and the signed range of the immediate.
    function automatic ent_t ref_encode(input logic [31:0] imm, input logic s,
                                        input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] r2);
        ent_t        e;
        int unsigned w;
        int          simm;
        simm = int'(imm);
        w = int'(op) + int'(f3) * 4096 + int'(rs1) * 32768;
        if (!s) w = w + int'(r2) * 128 + (imm & 32'hFFF) * 1048576;
        else    w = w + (imm & 32'h1F) * 128 + int'(r2) * 1048576 + ((imm >> 5) & 32'h7F) * 33554432;
        e.instr = w;
        e.err   = (simm < -2048) || (simm > 2047);
        return e;
    endfunction

    task automatic set_req(input vec_t v, input logic valid);
        bus.imm_i    = v.imm;
        bus.immsrc_i = v.immsrc;
        bus.opcode_i = v.op;
        bus.funct3_i = v.f3;
        bus.rs1_i    = v.rs1;
        bus.rdrs2_i  = v.rdrs2;
        bus.in_valid = valid;
    endtask

    task automatic tick();
        ent_t e;
        bit   acc;
        bit   cons;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, (mq.size() < 2)});
        if (mq.size() > 0) begin
            chk("out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("out_instr", {32'd0, bus.out_instr}, {32'd0, mq[0].instr});
            chk("out_err", {63'd0, bus.out_err}, {63'd0, mq[0].err});
        end else begin
            chk("out_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        chk("enc_count", {56'd0, bus.enc_count}, 64'(m_enc));
        chk("err_count", {56'd0, bus.err_count}, 64'(m_err));
        acc  = bus.in_valid && (mq.size() < 2) && !rst;
        cons = bus.out_ready && (mq.size() > 0) && !rst;
        e = ref_encode(bus.imm_i, bus.immsrc_i, bus.opcode_i, bus.funct3_i, bus.rs1_i, bus.rdrs2_i);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_enc = 0;
            m_err = 0;
        end else begin
            if (cons) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                m_enc = (m_enc + 1) % (1 << CNTW);
                if (e.err && m_err < 255) m_err++;
            end
        end
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int   errs;
        vec_t rv;
        n_cmp = 0;
        n_fail = 0;
        vecs[0] = '{32'hFFFF_FFFF, 1'b0, 7'h13, 3'd0, 5'd2, 5'd1, 32'hFFF1_0093, 1'b0};
        vecs[1] = '{32'h0000_0008, 1'b1, 7'h23, 3'd2, 5'd2, 5'd5, 32'h0051_2423, 1'b0};
        vecs[2] = '{32'h0000_0800, 1'b0, 7'h13, 3'd0, 5'd0, 5'd0, 32'h8000_0013, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 7'h23, 3'd2, 5'd4, 5'd3, 32'hFE32_2FA3, 1'b0};
        vecs[4] = '{32'h0000_07FF, 1'b0, 7'h13, 3'd0, 5'd0, 5'd0, 32'h7FF0_0013, 1'b0};
        vecs[5] = '{32'hFFFF_F800, 1'b0, 7'h13, 3'd0, 5'd0, 5'd0, 32'h8000_0013, 1'b0};
        vecs[6] = '{32'hFFFF_F7FF, 1'b0, 7'h13, 3'd0, 5'd0, 5'd0, 32'h7FF0_0013, 1'b1};
        vecs[7] = '{32'h0000_1000, 1'b1, 7'h23, 3'd0, 5'd0, 5'd0, 32'h0000_0023, 1'b1};

        set_req(vecs[0], 1'b0);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_enc = 0;
        m_err = 0;

        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_err", {63'd0, bus.out_err}, 64'd0);
        chk("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        chk("rst_enc_count", {56'd0, bus.enc_count}, 64'd0);
        chk("rst_err_count", {56'd0, bus.err_count}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        errs = 0;
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i], 1'b1);
            bus.out_ready = 1'b1;
            tick();
            errs += int'(vecs[i].exp_err);
            chk($sformatf("vec%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("vec%0d_instr", i), {32'd0, bus.out_instr}, {32'd0, vecs[i].exp_instr});
            chk($sformatf("vec%0d_err", i), {63'd0, bus.out_err}, {63'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_enc_count", i), {56'd0, bus.enc_count}, 64'(i + 1));
            chk($sformatf("vec%0d_err_count", i), {56'd0, bus.err_count}, 64'(errs));
            bus.in_valid = 1'b0;
            tick();
        end
        $display("table: %0d vectors applied", 8);

        // Backpressure: A to main, B to skid, C held until space frees up.
        mid_reset();
        bus.out_ready = 1'b0;
        set_req(vecs[0], 1'b1);
        tick();
        set_req(vecs[1], 1'b1);
        tick();
        chk("bp_in_ready_full", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_main_is_a", {32'd0, bus.out_instr}, {32'd0, vecs[0].exp_instr});
        set_req(vecs[3], 1'b1);
        tick();
        tick();
        chk("bp_c_held", {56'd0, bus.enc_count}, 64'd2);
        chk("bp_a_stable", {32'd0, bus.out_instr}, {32'd0, vecs[0].exp_instr});
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out_b", {32'd0, bus.out_instr}, {32'd0, vecs[1].exp_instr});
        tick();
        chk("bp_out_c", {32'd0, bus.out_instr}, {32'd0, vecs[3].exp_instr});
        bus.in_valid = 1'b0;
        tick();
        chk("bp_drained", {63'd0, bus.out_valid}, 64'd0);
        chk("bp_enc_count", {56'd0, bus.enc_count}, 64'd3);
        $display("backpressure: A/B/C sequence done");

        // Reset while FULL, with a simultaneous accept attempt.
        mid_reset();
        bus.out_ready = 1'b0;
        set_req(vecs[2], 1'b1);
        tick();
        set_req(vecs[7], 1'b1);
        tick();
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst = 1'b1;
        set_req(vecs[6], 1'b1);
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("full_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("full_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("full_rst_enc_count", {56'd0, bus.enc_count}, 64'd0);
        chk("full_rst_err_count", {56'd0, bus.err_count}, 64'd0);
        $display("reset-while-full sequence done");

        // Counter saturation and wrap.
        mid_reset();
        bus.out_ready = 1'b1;
        rv = vecs[0];
        for (int i = 0; i < 260; i++) begin
            rv.imm = 32'h0000_0800 + ($urandom & 32'h3FFF_F7FF);
            set_req(rv, 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("err_count_sat", {56'd0, bus.err_count}, 64'd255);
        chk("enc_count_260", {56'd0, bus.enc_count}, 64'd4);
        mid_reset();
        set_req(vecs[4], 1'b1);
        for (int i = 0; i < (1 << CNTW) + 1; i++) tick();
        bus.in_valid = 1'b0;
        tick();
        chk("enc_count_wrap", {56'd0, bus.enc_count}, 64'd1);
        $display("counters: saturation and wrap sequences done");

        // Random traffic against the model.
        mid_reset();
        for (int i = 0; i < 3000; i++) begin
            int t;
            case ($urandom_range(0, 3))
                0: begin t = int'($urandom_range(0, 4095)) - 2048; rv.imm = t; end
                1: begin t = int'($urandom_range(0, 7)); rv.imm = (t < 4) ? 32'(2044 + t) : 32'(-2052 + t); end
                2: rv.imm = $urandom;
                default: begin t = int'($urandom_range(0, 16383)) - 8192; rv.imm = t; end
            endcase
            rv.immsrc = 1'($urandom);
            rv.op     = 7'($urandom);
            rv.f3     = 3'($urandom);
            rv.rs1    = 5'($urandom);
            rv.rdrs2  = 5'($urandom);
            set_req(rv, ($urandom_range(0, 9) < 6));
            bus.out_ready = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        $display("random: 3000 cycles applied");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL take parameter DPW, default 32 (rv32i_pkg), giving the data path and instruction width.
REQ-002 The module SHALL take parameter CNTW, default 16, giving the width of the accepted-instruction counter.
REQ-003 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  an encode request is present on the request fields.
REQ-006 in_ready  output  1  the block can accept a request this cycle.
REQ-007 imm_i  input  DPW  sign-extended 32-bit immediate to pack.
REQ-008 immsrc_i  input  1  0 selects I-type layout, 1 selects S-type layout.
REQ-009 opcode_i  input  7  opcode, placed in instruction bits [6:0].
REQ-010 funct3_i  input  3  funct3, placed in bits [14:12].
REQ-011 rs1_i  input  5  rs1, placed in bits [19:15].
REQ-012 rdrs2_i  input  5  carries rd in I-type and rs2 in S-type.
REQ-013 out_valid  output  1  an encoded instruction is present on out_instr.
REQ-014 out_ready  input  1  the consumer accepts out_instr this cycle.
REQ-015 out_instr  output  DPW  encoded instruction word.
REQ-016 out_err  output  1  the immediate was not representable; qualified by out_valid.
REQ-017 enc_count  output  CNTW  count of accepted requests.
REQ-018 err_count  output  8  count of out-of-range requests.

Function
REQ-019 A request SHALL be accepted on a cycle where in_valid=1 and in_ready=1; an output SHALL be consumed on a cycle where out_valid=1 and out_ready=1.
REQ-020 I-type encoding SHALL be: imm[11:0] to bits [31:20], rs1, funct3, rd to bits [11:7], and opcode.
REQ-021 S-type encoding SHALL be: imm[11:5] to bits [31:25], rs2 to bits [24:20], rs1, funct3, imm[4:0] to bits [11:7], and opcode.
REQ-022 An immediate is out of range when imm_i[31:11] is not all-equal; out_err SHALL then be 1, and the instruction SHALL still be emitted using the truncated imm[11:0].
REQ-023 Latency SHALL be exactly one cycle: a request accepted at edge N SHALL appear with out_valid=1 after edge N when the output register is free or being consumed at that edge.
REQ-024 Buffering SHALL use a main output register plus one skid register, with output order strictly equal to acceptance order.
REQ-025 in_ready SHALL be a registered signal equal to the inverse of the skid-register-occupied flag.
REQ-026 When the main register holds data, out_ready=0, and a request is accepted, the new entry SHALL go to the skid register.
REQ-027 Occupancy states SHALL be EMPTY, ONE (main register only) and FULL (main and skid registers).
REQ-028 EMPTY SHALL go to ONE on an accept.
REQ-029 ONE SHALL go to EMPTY on a consume without an accept, SHALL go to FULL on an accept without a consume, and SHALL stay in ONE on a simultaneous accept and consume.
REQ-030 FULL SHALL go to ONE on a consume, with the skid entry moving to the main register; no accept is possible in FULL.
REQ-031 While out_valid=1 and out_ready=0, out_instr and out_err SHALL remain stable.
REQ-032 enc_count SHALL increment by 1 on each accept and wrap modulo 2^CNTW.
REQ-033 err_count SHALL increment on each out-of-range accept and saturate at 255.
REQ-034 Request fields SHALL be ignored when in_valid=0, and no X SHALL propagate to out_instr when out_valid=0.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL clear occupancy to EMPTY.
REQ-036 After that edge: out_valid=0, out_err=0, out_instr=0, enc_count=0, err_count=0.
REQ-037 On the cycle after reset, in_ready SHALL be 1.
REQ-038 A reset asserted mid-operation SHALL discard all buffered entries, and no output transfer SHALL occur on that edge.
REQ-039 An accept attempted in the same cycle as rst=1 SHALL be dropped and not counted.

Verification
REQ-040 I-type request with imm=0xFFFFFFFF, rs1=2, rd=1, funct3=0, opcode=0x13, and out_ready=1 -> next cycle out_instr=0xFFF10093, out_err=0, enc_count=1.
REQ-041 S-type request with imm=8, rs2=5, rs1=2, funct3=2, opcode=0x23 -> out_instr=0x00512423, out_err=0.
REQ-042 I-type request with imm=0x00000800 -> out_err=1, out_instr[31:20]=0x800, err_count=1.
REQ-043 out_ready=0 with three back-to-back valid requests A, B, C -> A in main, B in skid, in_ready=0, C held; then out_ready=1 -> outputs A, B, C in order with no loss or duplication.
REQ-044 256 consecutive out-of-range requests -> err_count saturates at 255; 2^CNTW+1 accepts -> enc_count=1.
REQ-045 rst=1 while FULL -> next cycle out_valid=0, in_ready=1, and both counters are 0.
